// File: rtl/neo_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// neo_pattern_sequencer
//
// Purpose:
//   Upstream feeder for the NeoPixel LED controller. Each frame it writes one
//   colour value per channel per pixel (NUM_PIXELS x 3 writes) over the load
//   handshake. It then requests a strip transmission over the send handshake
//   and holds for FRAME_CYCLES clocks. After the hold, the "chase" head
//   advances by one pixel. Each time the head wraps back to pixel 0, the lit
//   channel (hue) advances green -> red -> blue -> green.
//
// Optional feature (compile-time macro NEO_TRAIL_EN):
//   Defined   : the pixel one step behind the head also glows at BRIGHT>>2 on
//               the current hue channel. The head value wins when both
//               coincide (NUM_PIXELS == 1).
//   Undefined : only the head pixel is lit.
//
// Ports:
//   clock          in   system clock
//   reset_n        in   asynchronous, active-low reset
//   enable         in   run animation (sampled in IDLE and at end of frame)
//   ready_to_load  in   controller accepts a colour write
//   ready_to_send  in   controller can start a strip transmission
//   load_color     out  one-cycle write strobe
//   pixel_index    out  [2:0] pixel addressed by the write
//   color_index    out  [1:0] channel: 0=green 1=red 2=blue
//   color_level    out  [7:0] channel intensity
//   send_it        out  one-cycle transmit strobe
//   frame_done     out  one-cycle pulse when the hold interval ends
//   busy           out  high whenever the FSM is not in IDLE
//   state_dbg      out  [2:0] current FSM state encoding (debug only)
//
// Handshake semantics: a write or send is issued only after the matching
// ready line has been sampled high at a clock edge. The strobe appears on
// the following cycle and lasts exactly one cycle. While the ready line is
// low, the sequencer waits indefinitely and issues no strobe.
// -----------------------------------------------------------------------------
module neo_pattern_sequencer #(
    parameter int          NUM_PIXELS   = 8,
    parameter int          FRAME_CYCLES = 2500000,
    parameter logic [7:0]  BRIGHT       = 8'h20
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    output logic       load_color,
    output logic [2:0] pixel_index,
    output logic [1:0] color_index,
    output logic [7:0] color_level,
    output logic       send_it,
    output logic       frame_done,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int         CW       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);
    localparam logic [2:0] LAST_PIX = 3'(NUM_PIXELS - 1);
    localparam logic [1:0] LAST_CH  = 2'd2;
    localparam logic [1:0] LAST_HUE = 2'd2;

    // S_STROBE is the cycle in which load_color is high. S_GAP follows with
    // load_color low, so the controller has time to drop ready_to_load
    // before it is sampled again.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STROBE = 3'd2,
        S_GAP    = 3'd3,
        S_SEND   = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    pix_q, pix_d;
    logic [1:0]    ch_q, ch_d;
    logic [2:0]    pos_q, pos_d;
    logic [1:0]    hue_q, hue_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          load_q, load_d;
    logic [2:0]    pidx_q, pidx_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [7:0]    lvl_q, lvl_d;
    logic          send_q, send_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // Colour level for the pixel/channel currently being loaded.
    logic [7:0]    level;

`ifdef NEO_TRAIL_EN
    logic [2:0]    trail_pix;
    always_comb begin
        trail_pix = (pos_q == 3'd0) ? LAST_PIX : (pos_q - 3'd1);
    end

    always_comb begin
        level = 8'h00;
        if (pix_q == pos_q && ch_q == hue_q) begin
            level = BRIGHT;
        end else if (pix_q == trail_pix && ch_q == hue_q) begin
            level = BRIGHT >> 2;
        end
    end
`else
    always_comb begin
        level = 8'h00;
        if (pix_q == pos_q && ch_q == hue_q) begin
            level = BRIGHT;
        end
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        ch_d    = ch_q;
        pos_d   = pos_q;
        hue_d   = hue_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        pidx_d  = pidx_q;
        cidx_d  = cidx_q;
        lvl_d   = lvl_q;
        send_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    pix_d   = 3'd0;
                    ch_d    = 2'd0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (ready_to_load) begin
                    load_d  = 1'b1;
                    pidx_d  = pix_q;
                    cidx_d  = ch_q;
                    lvl_d   = level;
                    state_d = S_STROBE;
                end
            end

            S_STROBE: begin
                state_d = S_GAP;
            end

            S_GAP: begin
                if (pix_q == LAST_PIX && ch_q == LAST_CH) begin
                    pix_d   = 3'd0;
                    ch_d    = 2'd0;
                    state_d = S_SEND;
                end else begin
                    if (ch_q == LAST_CH) begin
                        ch_d  = 2'd0;
                        pix_d = pix_q + 3'd1;
                    end else begin
                        ch_d  = ch_q + 2'd1;
                    end
                    state_d = S_LOAD;
                end
            end

            S_SEND: begin
                if (ready_to_send) begin
                    send_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                // The first HOLD cycle coincides with send_it. frame_done is
                // registered, so it lands FRAME_CYCLES cycles after send_it.
                if (cnt_q == LAST_CNT) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (pos_q == LAST_PIX) begin
                        pos_d = 3'd0;
                        hue_d = (hue_q == LAST_HUE) ? 2'd0 : (hue_q + 2'd1);
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                    state_d = enable ? S_LOAD : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pix_q   <= 3'd0;
            ch_q    <= 2'd0;
            pos_q   <= 3'd0;
            hue_q   <= 2'd0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            pidx_q  <= 3'd0;
            cidx_q  <= 2'd0;
            lvl_q   <= 8'h00;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            ch_q    <= ch_d;
            pos_q   <= pos_d;
            hue_q   <= hue_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            pidx_q  <= pidx_d;
            cidx_q  <= cidx_d;
            lvl_q   <= lvl_d;
            send_q  <= send_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign load_color  = load_q;
    assign pixel_index = pidx_q;
    assign color_index = cidx_q;
    assign color_level = lvl_q;
    assign send_it     = send_q;
    assign frame_done  = done_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_neo_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neo_pattern_sequencer
//
// Self-checking bench for neo_pattern_sequencer with FRAME_CYCLES=10.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge. The expected load sequence (pixel, channel, level) for each frame is
// pushed into exp_q from a small model of the chase position and hue, and it
// is popped as strobes arrive.
// -----------------------------------------------------------------------------
module tb_neo_pattern_sequencer;

    localparam int NP = 8;
    localparam int FC = 10;
    localparam int LOADS = NP * 3;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       load_color;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       send_it;
    logic       frame_done;
    logic       busy;
    logic [2:0] state_dbg;

    int checks = 0;
    int fails  = 0;

    int model_pos = 0;
    int model_hue = 0;

    logic [12:0] exp_q[$];
    logic        rdy_prev = 1'b0;

    neo_pattern_sequencer #(
        .NUM_PIXELS  (NP),
        .FRAME_CYCLES(FC),
        .BRIGHT      (8'h20)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send),
        .load_color   (load_color),
        .pixel_index  (pixel_index),
        .color_index  (color_index),
        .color_level  (color_level),
        .send_it      (send_it),
        .frame_done   (frame_done),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ready_to_load as seen by the DUT at the latest rising edge
    always @(posedge clock) rdy_prev = ready_to_load;

    // Protocol watch: strobes never overlap, writes only follow a sampled ready.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (load_color === 1'b1 || send_it === 1'b1) begin
                checks++;
                if (load_color === 1'b1 && send_it === 1'b1) begin
                    fails++;
                    $display("FAIL strobe_overlap: load_color=%b send_it=%b, required not both 1",
                             load_color, send_it);
                end
            end
            if (load_color === 1'b1) begin
                checks++;
                if (rdy_prev !== 1'b1) begin
                    fails++;
                    $display("FAIL load_without_ready: ready_to_load sampled=%b, required 1", rdy_prev);
                end
            end
        end
    end

    function automatic logic [7:0] exp_level(int p, int c, int pos, int hue);
        if (p == pos && c == hue) return 8'h20;
`ifdef NEO_TRAIL_EN
        if (p == ((pos + NP - 1) % NP) && c == hue) return 8'h08;
`endif
        return 8'h00;
    endfunction

    // One full frame. stall_load_idx: after that many loads, hold ready_to_load
    // low for 50 cycles. stall_send: cycles to hold ready_to_send low.
    // disable_idx: drop enable after that many loads.
    task automatic run_frame(input int stall_load_idx, input int stall_send, input int disable_idx);
        int k;
        int cyc;
        int t;
        logic [12:0] expv;
        logic [12:0] act;
        logic        exp_busy;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                exp_q.push_back({3'(p), 2'(c), exp_level(p, c, model_pos, model_hue)});

        k = 0;
        cyc = 0;
        while (k < LOADS && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            if (load_color === 1'b1) begin
                act  = {pixel_index, color_index, color_level};
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1fff;
                checks++;
                if (act !== expv) begin
                    fails++;
                    $display("FAIL load_%0d: got pix=%0d ch=%0d lvl=%h, required pix=%0d ch=%0d lvl=%h",
                             k, act[12:10], act[9:8], act[7:0], expv[12:10], expv[9:8], expv[7:0]);
                end
                k++;
                if (k == disable_idx) enable = 1'b0;
                if (k == stall_load_idx) begin
                    ready_to_load = 1'b0;
                    repeat (50) begin
                        @(negedge clock);
                        checks++;
                        if (load_color !== 1'b0) begin
                            fails++;
                            $display("FAIL load_stall: load_color=%b, required 0", load_color);
                        end
                    end
                    ready_to_load = 1'b1;
                end
            end
        end
        checks++;
        if (k != LOADS) begin
            fails++;
            $display("FAIL load_count: got %0d loads, required %0d", k, LOADS);
        end

        if (stall_send > 0) begin
            ready_to_send = 1'b0;
            repeat (stall_send) begin
                @(negedge clock);
                checks++;
                if (send_it !== 1'b0) begin
                    fails++;
                    $display("FAIL send_stall: send_it=%b, required 0", send_it);
                end
            end
            ready_to_send = 1'b1;
        end

        cyc = 0;
        while (send_it !== 1'b1 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (load_color === 1'b1) begin
                checks++;
                fails++;
                $display("FAIL extra_load: load_color=1 before send, required 0");
            end
        end
        checks++;
        if (send_it !== 1'b1) begin
            fails++;
            $display("FAIL send_timeout: send_it=%b, required 1", send_it);
        end

        t = 0;
        while (frame_done !== 1'b1 && t < FC + 20) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (t != FC) begin
            fails++;
            $display("FAIL frame_done_delay: got %0d cycles after send_it, required %0d", t, FC);
        end

        exp_busy = enable;
        checks++;
        if (busy !== exp_busy) begin
            fails++;
            $display("FAIL busy_after_frame: busy=%b, required %b", busy, exp_busy);
        end

        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_residue: %0d entries left, required 0", exp_q.size());
        end
        exp_q.delete();

        if (model_pos == NP - 1) begin
            model_pos = 0;
            model_hue = (model_hue == 2) ? 0 : model_hue + 1;
        end else begin
            model_pos = model_pos + 1;
        end
    endtask

    task automatic test_reset;
        reset_n       = 1'b0;
        enable        = 1'b0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({load_color, pixel_index, color_index, color_level, send_it, frame_done, busy} !== 17'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {load_color, pixel_index, color_index, color_level, send_it, frame_done, busy});
        end
        reset_n = 1'b1;
        repeat (100) begin
            @(negedge clock);
            checks++;
            if ({load_color, pixel_index, color_index, color_level, send_it, frame_done, busy} !== 17'h0) begin
                fails++;
                $display("FAIL idle_outputs: got %h, required 0",
                         {load_color, pixel_index, color_index, color_level, send_it, frame_done, busy});
            end
        end
    endtask

    task automatic test_first_frame;
        model_pos = 0;
        model_hue = 0;
        enable = 1'b1;
        run_frame(-1, 0, -1);
    endtask

    task automatic test_wrap;
        // Frames 2..9; frame 9 must have the head back at pixel 0 on red.
        for (int f = 0; f < 8; f++) run_frame(-1, 0, -1);
    endtask

    task automatic test_stall;
        // Stall begins when (pix3,ch1) is next: after 10 loads.
        run_frame(10, 30, -1);
    endtask

    task automatic test_disable_mid_frame;
        run_frame(-1, 0, 5);
        repeat (20) begin
            @(negedge clock);
            checks++;
            if (busy !== 1'b0 || load_color !== 1'b0 || send_it !== 1'b0) begin
                fails++;
                $display("FAIL idle_after_disable: busy=%b load=%b send=%b, required 0 0 0",
                         busy, load_color, send_it);
            end
        end
    endtask

    task automatic test_reset_mid_load;
        int k;
        int cyc;
        enable = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 500) begin
            @(negedge clock);
            cyc++;
            if (load_color === 1'b1) k++;
        end
        checks++;
        if (k != 4) begin
            fails++;
            $display("FAIL pre_reset_loads: got %0d, required 4", k);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({load_color, pixel_index, color_index, color_level, send_it, frame_done, busy} !== 17'h0) begin
            fails++;
            $display("FAIL async_reset_clear: got %h, required 0",
                     {load_color, pixel_index, color_index, color_level, send_it, frame_done, busy});
        end
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        model_pos = 0;
        model_hue = 0;
        run_frame(-1, 0, -1);
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_wrap();
        test_stall();
        test_disable_mid_frame();
        test_reset_mid_load();
        repeat (30) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
